// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, one-word-per-line cache controller between a CPU load/store port
// and a memory port: hit/miss lookup, miss fill, write-through without allocate, flush.
module dm_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              cpu_resp_hit,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    RESPOND  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_hit;
  logic              flush_pending;

  logic [LINES-1:0]  valid_bits;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              lookup_hit;
  logic              accept;
  logic              fill;
  logic              mem_done;

  assign req_idx    = req_addr[IDX_W+1:2];
  assign req_tag    = req_addr[ADDR_W-1:IDX_W+2];
  assign lookup_hit = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the requester holds its payload stable from valid until that edge. The CPU response
  // and the memory response are single-cycle pulses with no back-pressure.
  assign accept   = (state == IDLE) && cpu_req_valid && cpu_req_ready;
  assign mem_done = (state == MEM_WAIT) && mem_resp_valid;
  assign fill     = mem_done && !req_we;

  assign mem_req_we     = req_we;
  assign mem_req_addr   = {req_addr[ADDR_W-1:2], 2'b00};
  assign mem_req_wdata  = req_wdata;
  assign cpu_resp_valid = (state == RESPOND);

  always_comb begin
    state_next    = state;
    cpu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        cpu_req_ready = !flush && !flush_pending;
        if (cpu_req_valid && !flush && !flush_pending) state_next = LOOKUP;
      end
      LOOKUP:   state_next = (lookup_hit && !req_we) ? RESPOND : MEM_REQ;
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = MEM_WAIT;
      end
      MEM_WAIT: if (mem_resp_valid) state_next = RESPOND;
      RESPOND:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_hit        <= 1'b0;
      flush_pending  <= 1'b0;
      valid_bits     <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
      cpu_resp_rdata <= '0;
      cpu_resp_hit   <= 1'b0;
    end else begin
      state <= state_next;

      if (accept) begin
        req_we    <= cpu_req_we;
        req_addr  <= cpu_req_addr;
        req_wdata <= cpu_req_wdata;
      end

      // A flush seen while busy is deferred so an in-flight fill cannot revive a line.
      if (state == IDLE) flush_pending <= 1'b0;
      else if (flush)    flush_pending <= 1'b1;

      if ((state == IDLE) && (flush || flush_pending)) valid_bits <= '0;
      else if (fill) valid_bits[req_idx] <= 1'b1;

      if (state == LOOKUP) begin
        req_hit <= lookup_hit;
        if (lookup_hit) begin
          if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + CNT_W'(1);
        end else begin
          if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
        end
        if (lookup_hit && !req_we) begin
          cpu_resp_rdata <= data_mem[req_idx];
          cpu_resp_hit   <= 1'b1;
        end
      end

      if (mem_done) begin
        cpu_resp_rdata <= req_we ? '0 : mem_resp_rdata;
        cpu_resp_hit   <= req_hit;
      end
    end
  end

  // Tag/data storage needs no reset: stale contents are masked by valid_bits.
  always_ff @(posedge clk) begin
    if ((state == LOOKUP) && lookup_hit && req_we) data_mem[req_idx] <= req_wdata;
    if (fill) begin
      data_mem[req_idx] <= mem_resp_rdata;
      tag_mem[req_idx]  <= req_tag;
    end
  end

endmodule
